i2s_tx_sched: RTL and testbench

- Sample scheduler that feeds the i2s_tx left_chan/right_chan inputs from NUM_SRC stereo sample streams, using per-frame round-robin arbitration.
- Runs in the sclk domain next to i2s_tx. Tracks frame boundaries by watching the transmitter's lrclk output.
- Delivers exactly one stereo sample per frame and handles mute, enable and underrun accounting.

---
 rtl/i2s_pkg.sv | 26 ++
 rtl/i2s_rr_arbiter.sv | 39 +++
 rtl/i2s_tx_sched.sv | 168 ++++++++++++++++
 tb/tb_i2s_tx_sched.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and helpers for the i2s sample scheduler.
// src_slice works on a fixed-width bus so it can serve any AUDIO_DW/NUM_SRC that fits.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    HOLD = 2'd2
  } sched_state_e;

  localparam int UCNT_W_DEF  = 16;
  // Widest packed source bus and widest channel sample src_slice can handle.
  localparam int SLICE_BUS_W = 1024;
  localparam int SLICE_MAX_W = 64;

  function automatic logic [SLICE_MAX_W-1:0] src_slice(
    input logic [SLICE_BUS_W-1:0] bus,
    input int unsigned            i,
    input int unsigned            dw
  );
    logic [SLICE_BUS_W-1:0] shifted;
    shifted = bus >> (i * dw);
    return shifted[SLICE_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/i2s_rr_arbiter.sv
// Combinational round-robin grant: first requester at or after ptr, wrapping
// modulo NUM_SRC.
module i2s_rr_arbiter #(
  parameter int NUM_SRC = 2
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] ptr,
  output logic [$clog2(NUM_SRC)-1:0] grant_idx,
  output logic                       grant_vld
);

  localparam int IDX_W = $clog2(NUM_SRC);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_SRC) begin
        cand = cand - NUM_SRC;
      end else begin
        cand = cand;
      end
      cand_idx = IDX_W'(cand);
      if (!grant_vld && req[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end else begin
        grant_vld = grant_vld;
      end
    end
  end

endmodule

// File: rtl/i2s_tx_sched.sv
// Per-frame round-robin sample scheduler feeding i2s_tx left/right channel inputs.
// Frame boundaries come from the falling edge of the transmitter's lrclk.
module i2s_tx_sched
  import i2s_pkg::*;
#(
  parameter int AUDIO_DW = 32,
  parameter int NUM_SRC  = 2,
  parameter int UCNT_W   = UCNT_W_DEF
) (
  input  logic                         sclk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         mute,
  input  logic                         lrclk,
  input  logic [NUM_SRC-1:0]           src_valid,
  output logic [NUM_SRC-1:0]           src_ready,
  input  logic [NUM_SRC*AUDIO_DW-1:0]  src_left,
  input  logic [NUM_SRC*AUDIO_DW-1:0]  src_right,
  output logic [AUDIO_DW-1:0]          left_chan,
  output logic [AUDIO_DW-1:0]          right_chan,
  output logic [$clog2(NUM_SRC)-1:0]   active_src,
  output logic                         frame_done,
  output logic                         underrun,
  output logic [UCNT_W-1:0]            underrun_cnt
);

  localparam int               IDX_W    = $clog2(NUM_SRC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);
  localparam logic [UCNT_W-1:0] UCNT_MAX = {UCNT_W{1'b1}};

  sched_state_e         state_q, state_d;
  logic                 lrclk_q;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 primed_q, primed_d;
  logic [AUDIO_DW-1:0]  left_q, left_d;
  logic [AUDIO_DW-1:0]  right_q, right_d;
  logic [IDX_W-1:0]     active_q, active_d;
  logic                 frame_done_q, frame_done_d;
  logic                 underrun_q, underrun_d;
  logic [UCNT_W-1:0]    ucnt_q, ucnt_d;

  logic                 load_evt;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_vld;
  logic [NUM_SRC-1:0]   ready_s;
  logic                 handshake;
  logic [AUDIO_DW-1:0]  grant_left;
  logic [AUDIO_DW-1:0]  grant_right;

  i2s_rr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_arb (
    .req       (src_valid),
    .ptr       (rr_ptr_q),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign load_evt = lrclk_q & ~lrclk;

  always_comb begin
    ready_s     = '0;
    grant_left  = AUDIO_DW'(src_slice(SLICE_BUS_W'(src_left),  32'(grant_idx), AUDIO_DW));
    grant_right = AUDIO_DW'(src_slice(SLICE_BUS_W'(src_right), 32'(grant_idx), AUDIO_DW));
    if (enable && (state_q == ARB) && grant_vld) begin
      ready_s[grant_idx] = 1'b1;
    end else begin
      ready_s = '0;
    end
    handshake = |(ready_s & src_valid);
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    primed_d     = primed_q;
    left_d       = left_q;
    right_d      = right_q;
    active_d     = active_q;
    underrun_d   = 1'b0;
    ucnt_d       = ucnt_q;
    frame_done_d = load_evt && (state_q != IDLE);

    // Dropping enable wins over everything; the underrun count is sticky.
    if (!enable) begin
      state_d  = IDLE;
      rr_ptr_d = '0;
      primed_d = 1'b0;
      left_d   = '0;
      right_d  = '0;
      active_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          rr_ptr_d = '0;
          primed_d = 1'b0;
          left_d   = '0;
          right_d  = '0;
          active_d = '0;
          state_d  = ARB;
        end
        ARB: begin
          if (load_evt && primed_q) begin
            underrun_d = 1'b1;
            ucnt_d     = (ucnt_q == UCNT_MAX) ? ucnt_q : ucnt_q + UCNT_W'(1);
          end else begin
            underrun_d = 1'b0;
          end
          if (handshake) begin
            left_d   = mute ? '0 : grant_left;
            right_d  = mute ? '0 : grant_right;
            active_d = grant_idx;
            rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
            primed_d = 1'b1;
            state_d  = HOLD;
          end else begin
            state_d = ARB;
          end
        end
        HOLD: begin
          if (load_evt) begin
            state_d = ARB;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lrclk_q      <= 1'b1;
      rr_ptr_q     <= '0;
      primed_q     <= 1'b0;
      left_q       <= '0;
      right_q      <= '0;
      active_q     <= '0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      ucnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      lrclk_q      <= lrclk;
      rr_ptr_q     <= rr_ptr_d;
      primed_q     <= primed_d;
      left_q       <= left_d;
      right_q      <= right_d;
      active_q     <= active_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
      ucnt_q       <= ucnt_d;
    end
  end

  assign src_ready    = ready_s;
  assign left_chan    = left_q;
  assign right_chan   = right_q;
  assign active_src   = active_q;
  assign frame_done   = frame_done_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_i2s_tx_sched.sv
// Scoreboard bench for i2s_tx_sched: bench-generated lrclk, expected samples queued
// at stimulus time and compared one edge after each observed handshake.
module tb_i2s_tx_sched;

  localparam int DW = 32;
  localparam int NS = 2;

  logic              sclk = 1'b0;
  logic              rst_n, enable, mute, lrclk;
  logic [NS-1:0]     src_valid;
  logic [NS*DW-1:0]  src_left, src_right;
  logic [NS-1:0]     src_ready, src_ready2;
  logic [DW-1:0]     left_chan, right_chan, left2, right2;
  logic              active_src, active2;
  logic              frame_done, frame_done2, underrun, underrun2;
  logic [15:0]       ucnt;
  logic [1:0]        ucnt2;

  int n_checks = 0;
  int n_fail   = 0;
  int lr_cnt;
  int exp_ucnt;

  typedef struct { int src; logic [DW-1:0] l; logic [DW-1:0] r; } exp_t;
  exp_t sb[$];
  exp_t e;

  i2s_tx_sched #(.AUDIO_DW(DW), .NUM_SRC(NS), .UCNT_W(16)) dut (
    .sclk(sclk), .rst_n(rst_n), .enable(enable), .mute(mute), .lrclk(lrclk),
    .src_valid(src_valid), .src_ready(src_ready), .src_left(src_left), .src_right(src_right),
    .left_chan(left_chan), .right_chan(right_chan), .active_src(active_src),
    .frame_done(frame_done), .underrun(underrun), .underrun_cnt(ucnt));

  i2s_tx_sched #(.AUDIO_DW(DW), .NUM_SRC(NS), .UCNT_W(2)) dut_sat (
    .sclk(sclk), .rst_n(rst_n), .enable(enable), .mute(mute), .lrclk(lrclk),
    .src_valid(src_valid), .src_ready(src_ready2), .src_left(src_left), .src_right(src_right),
    .left_chan(left2), .right_chan(right2), .active_src(active2),
    .frame_done(frame_done2), .underrun(underrun2), .underrun_cnt(ucnt2));

  always #5 sclk = ~sclk;

  // lrclk as i2s_tx would produce it: 64-cycle frame, falls when lr_cnt wraps to 0.
  initial begin
    lr_cnt = 40;
    lrclk  = 1'b1;
    forever begin
      @(posedge sclk);
      #2;
      lr_cnt = (lr_cnt + 1) % 64;
      lrclk  = (lr_cnt < 32) ? 1'b0 : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(negedge sclk);
    #1;
  endtask

  task automatic wait_hs(input int max, output bit ok);
    ok = 1'b0;
    #1;
    for (int i = 0; i < max; i++) begin
      if ((src_ready & src_valid) != '0) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic wait_load(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (lr_cnt == 0) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; mute = 1'b0; src_valid = '0;
    src_left = '0; src_right = '0; exp_ucnt = 0;
    repeat (3) step();
    n_checks++; if (left_chan !== 32'h0) begin n_fail++; $display("FAIL reset_left: got %h want 0", left_chan); end
    n_checks++; if (right_chan !== 32'h0) begin n_fail++; $display("FAIL reset_right: got %h want 0", right_chan); end
    n_checks++; if (src_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", src_ready); end
    n_checks++; if (active_src !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", active_src); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    n_checks++; if (ucnt !== 16'd0) begin n_fail++; $display("FAIL reset_ucnt: got %0d want 0", ucnt); end
    rst_n = 1'b1;
    step();
    n_checks++; if (left_chan !== 32'h0) begin n_fail++; $display("FAIL idle_left: got %h want 0", left_chan); end
  endtask

  task automatic test_basic();
    int hs_cnt;
    src_left[31:0] = 32'hA5A5_0001; src_right[31:0] = 32'h5A5A_0001;
    src_valid = 2'b01;
    sb.push_back('{0, 32'hA5A5_0001, 32'h5A5A_0001});
    enable = 1'b1;
    step();
    n_checks++; if (src_ready !== 2'b01) begin n_fail++; $display("FAIL basic_first_arb_ready: got %b want 01", src_ready); end
    step();
    e = sb.pop_front();
    n_checks++; if (left_chan !== e.l) begin n_fail++; $display("FAIL basic_left: got %h want %h", left_chan, e.l); end
    n_checks++; if (right_chan !== e.r) begin n_fail++; $display("FAIL basic_right: got %h want %h", right_chan, e.r); end
    n_checks++; if (src_ready !== 2'b00) begin n_fail++; $display("FAIL basic_hold_ready: got %b want 00", src_ready); end
    hs_cnt = 0;
    for (int i = 0; i < 192; i++) begin
      step();
      if ((src_ready & src_valid) != '0) hs_cnt++;
    end
    n_checks++; if (hs_cnt != 3) begin n_fail++; $display("FAIL basic_rate: got %0d transfers want 3 in 192 cycles", hs_cnt); end
    n_checks++; if (left_chan !== 32'hA5A5_0001) begin n_fail++; $display("FAIL basic_left_steady: got %h want a5a50001", left_chan); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp_src;
    logic [NS-1:0] exp_rdy;
    logic [DW-1:0] l_tab [NS];
    logic [DW-1:0] r_tab [NS];
    enable = 1'b0;
    step(); step();
    l_tab[0] = 32'hA0A0_0000; l_tab[1] = 32'hB1B1_0001;
    r_tab[0] = 32'hC0C0_1000; r_tab[1] = 32'hD1D1_1001;
    src_left = {l_tab[1], l_tab[0]}; src_right = {r_tab[1], r_tab[0]};
    src_valid = 2'b11;
    enable = 1'b1;
    exp_src = 0;
    for (int f = 0; f < 4; f++) begin
      sb.push_back('{exp_src, l_tab[exp_src], r_tab[exp_src]});
      exp_rdy = NS'(1) << exp_src;
      wait_hs(140, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_timeout: frame %0d got no handshake want one", f); end
      n_checks++; if (src_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_ready: frame %0d got %b want %b", f, src_ready, exp_rdy); end
      step();
      e = sb.pop_front();
      n_checks++; if (active_src !== 1'(e.src)) begin n_fail++; $display("FAIL rr_active: frame %0d got %0d want %0d", f, active_src, e.src); end
      n_checks++; if (left_chan !== e.l) begin n_fail++; $display("FAIL rr_left: frame %0d got %h want %h", f, left_chan, e.l); end
      n_checks++; if (src_ready !== 2'b00) begin n_fail++; $display("FAIL rr_pulse_width: frame %0d got %b want 00", f, src_ready); end
      exp_src = (exp_src + 1) % NS;
    end
  endtask

  task automatic test_underrun();
    bit ok;
    int ur_seen;
    enable = 1'b0;
    step(); step();
    src_left[31:0] = 32'hC0C0_0001; src_right[31:0] = 32'h0C0C_0001;
    src_valid = 2'b01;
    sb.push_back('{0, 32'hC0C0_0001, 32'h0C0C_0001});
    enable = 1'b1;
    wait_hs(10, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ur_prime_timeout: got no handshake want one"); end
    step();
    src_valid = 2'b00;
    e = sb.pop_front();
    n_checks++; if (left_chan !== e.l) begin n_fail++; $display("FAIL ur_prime_left: got %h want %h", left_chan, e.l); end
    ur_seen = 0;
    for (int i = 0; i < 300 && ur_seen < 3; i++) begin
      step();
      if (underrun === 1'b1) ur_seen++;
    end
    exp_ucnt = 3;
    n_checks++; if (ur_seen != 3) begin n_fail++; $display("FAIL ur_pulses: got %0d want 3", ur_seen); end
    n_checks++; if (ucnt !== 16'(exp_ucnt)) begin n_fail++; $display("FAIL ur_cnt3: got %0d want %0d", ucnt, exp_ucnt); end
    n_checks++; if (left_chan !== 32'hC0C0_0001) begin n_fail++; $display("FAIL ur_left_held: got %h want c0c00001", left_chan); end
    n_checks++; if (right_chan !== 32'h0C0C_0001) begin n_fail++; $display("FAIL ur_right_held: got %h want 0c0c0001", right_chan); end
    for (int i = 0; i < 200 && ur_seen < 5; i++) begin
      step();
      if (underrun === 1'b1) ur_seen++;
    end
    exp_ucnt = 5;
    n_checks++; if (ucnt !== 16'(exp_ucnt)) begin n_fail++; $display("FAIL ur_cnt5: got %0d want %0d", ucnt, exp_ucnt); end
    n_checks++; if (ucnt2 !== 2'd3) begin n_fail++; $display("FAIL ur_saturate: got %0d want 3", ucnt2); end
    step();
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL ur_pulse_width: got %b want 0", underrun); end
  endtask

  task automatic test_mute();
    bit ok;
    mute = 1'b1;
    src_left[63:32] = 32'h1234_5678; src_right[63:32] = 32'h8765_4321;
    src_valid = 2'b10;
    sb.push_back('{1, 32'h0, 32'h0});
    wait_hs(10, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mute_timeout: got no handshake want one"); end
    step();
    e = sb.pop_front();
    n_checks++; if (left_chan !== e.l) begin n_fail++; $display("FAIL mute_left: got %h want %h", left_chan, e.l); end
    n_checks++; if (right_chan !== e.r) begin n_fail++; $display("FAIL mute_right: got %h want %h", right_chan, e.r); end
    n_checks++; if (active_src !== 1'(e.src)) begin n_fail++; $display("FAIL mute_active: got %0d want %0d", active_src, e.src); end
    mute = 1'b0;
    src_left[63:32] = 32'h0BAD_F00D; src_right[63:32] = 32'hF00D_0BAD;
    sb.push_back('{1, 32'h0BAD_F00D, 32'hF00D_0BAD});
    wait_hs(140, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL unmute_timeout: got no handshake want one"); end
    step();
    e = sb.pop_front();
    n_checks++; if (left_chan !== e.l) begin n_fail++; $display("FAIL unmute_left: got %h want %h", left_chan, e.l); end
    src_valid = 2'b00;
    mute = 1'b1;
    repeat (20) step();
    n_checks++; if (left_chan !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL mute_held_data: got %h want 0badf00d", left_chan); end
    mute = 1'b0;
  endtask

  task automatic test_enable_drop();
    enable = 1'b0;
    step(); step();
    src_left[31:0] = 32'h5555_AAAA;
    enable = 1'b1;
    step(); step();
    src_valid = 2'b01;
    enable = 1'b0;
    #1;
    n_checks++; if (src_ready !== 2'b00) begin n_fail++; $display("FAIL en_drop_ready_now: got %b want 00", src_ready); end
    step();
    n_checks++; if (left_chan !== 32'h0) begin n_fail++; $display("FAIL en_drop_left: got %h want 0", left_chan); end
    n_checks++; if (right_chan !== 32'h0) begin n_fail++; $display("FAIL en_drop_right: got %h want 0", right_chan); end
    n_checks++; if (src_ready !== 2'b00) begin n_fail++; $display("FAIL en_drop_ready: got %b want 00", src_ready); end
    n_checks++; if (ucnt !== 16'(exp_ucnt)) begin n_fail++; $display("FAIL en_drop_ucnt_kept: got %0d want %0d", ucnt, exp_ucnt); end
  endtask

  task automatic test_reset_hold();
    bit ok;
    src_left[31:0] = 32'h7777_0001; src_right[31:0] = 32'h7777_0002;
    src_valid = 2'b01;
    sb.push_back('{0, 32'h7777_0001, 32'h7777_0002});
    enable = 1'b1;
    wait_hs(10, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_prime_timeout: got no handshake want one"); end
    step();
    e = sb.pop_front();
    n_checks++; if (left_chan !== e.l) begin n_fail++; $display("FAIL rst_prime_left: got %h want %h", left_chan, e.l); end
    src_valid = 2'b00;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    exp_ucnt = 0;
    n_checks++; if (left_chan !== 32'h0 || right_chan !== 32'h0) begin n_fail++; $display("FAIL rst_async_data: got %h/%h want 0/0", left_chan, right_chan); end
    n_checks++; if (src_ready !== 2'b00 || active_src !== 1'b0) begin n_fail++; $display("FAIL rst_async_ctl: got ready %b active %b want 00/0", src_ready, active_src); end
    n_checks++; if (ucnt !== 16'(exp_ucnt) || ucnt2 !== 2'd0) begin n_fail++; $display("FAIL rst_async_ucnt: got %0d/%0d want 0/0", ucnt, ucnt2); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_simultaneous();
    bit ok;
    src_left[31:0] = 32'hE000_0001; src_right[31:0] = 32'hE000_0002;
    src_valid = 2'b01;
    sb.push_back('{0, 32'hE000_0001, 32'hE000_0002});
    wait_hs(10, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL sim_prime_timeout: got no handshake want one"); end
    step();
    src_valid = 2'b00;
    e = sb.pop_front();
    n_checks++; if (left_chan !== e.l) begin n_fail++; $display("FAIL sim_prime_left: got %h want %h", left_chan, e.l); end
    step();
    wait_load(70, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL sim_load1_timeout: got no frame edge want one"); end
    step(); step();
    wait_load(70, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL sim_load2_timeout: got no frame edge want one"); end
    src_left[31:0] = 32'hF000_0001; src_right[31:0] = 32'hF000_0002;
    src_valid = 2'b01;
    sb.push_back('{0, 32'hF000_0001, 32'hF000_0002});
    exp_ucnt = exp_ucnt + 1;
    step();
    e = sb.pop_front();
    n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL sim_underrun: got %b want 1", underrun); end
    n_checks++; if (ucnt !== 16'(exp_ucnt)) begin n_fail++; $display("FAIL sim_ucnt: got %0d want %0d", ucnt, exp_ucnt); end
    n_checks++; if (left_chan !== e.l) begin n_fail++; $display("FAIL sim_left: got %h want %h", left_chan, e.l); end
    n_checks++; if (src_ready !== 2'b00) begin n_fail++; $display("FAIL sim_hold_ready: got %b want 00", src_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_underrun();
    test_mute();
    test_enable_drop();
    test_reset_hold();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
